// File: rtl/traffic_light_ctrl_n_if.sv
// traffic_light_ctrl_n_if: demand, preemption and lamp signals between controller and its environment
interface traffic_light_ctrl_n_if #(
  parameter int NUM_DIR = 2
);
  localparam int DIR_W = NUM_DIR > 1 ? $clog2(NUM_DIR) : 1;
  logic                 tick_en;
  logic [NUM_DIR-1:0]   dir_req;
  logic                 emerg;
  logic [DIR_W-1:0]     emerg_dir;
  logic [2*NUM_DIR-1:0] lights;
  logic [DIR_W-1:0]     active_dir;
  logic [1:0]           phase;
  logic                 emerg_ack;
  modport master (
    output tick_en, dir_req, emerg, emerg_dir,
    input  lights, active_dir, phase, emerg_ack
  );
  modport slave (
    input  tick_en, dir_req, emerg, emerg_dir,
    output lights, active_dir, phase, emerg_ack
  );
endinterface

// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n: round-robin N-approach traffic light controller with demand skip and emergency preemption
module traffic_light_ctrl_n #(
  parameter int NUM_DIR      = 2,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 30,
  parameter int YELLOW_TICKS = 5,
  parameter int ALLRED_TICKS = 2
) (
  input logic clk,
  input logic clear,
  traffic_light_ctrl_n_if.slave bus
);
  localparam int DIR_W = NUM_DIR > 1 ? $clog2(NUM_DIR) : 1;
  localparam logic [1:0] PH_G = 2'd0, PH_Y = 2'd1, PH_AR = 2'd2;
  localparam logic [DIR_W:0] NUM_L = (DIR_W+1)'(NUM_DIR);
  localparam logic [CNT_W-1:0] G_END = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_END = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_END = CNT_W'(ALLRED_TICKS - 1);
  logic [1:0]       phase;
  logic [DIR_W-1:0] active, next_dir, sel;
  logic [CNT_W-1:0] count;
  logic             found, emerg_ok, hold;
  assign emerg_ok = bus.emerg && ({1'b0, bus.emerg_dir} < NUM_L);
  assign hold = emerg_ok && bus.emerg_dir == active;
  // descending scan so the nearest requester after active wins
  always_comb begin
    found = 1'b0;
    sel = active;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      if (bus.dir_req[DIR_W'((int'(active) + k) % NUM_DIR)]) begin
        found = 1'b1;
        sel = DIR_W'((int'(active) + k) % NUM_DIR);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      phase <= PH_G;
      active <= '0;
      count <= '0;
      next_dir <= '0;
    end else if (phase == PH_G) begin
      if (hold) count <= '0;
      else if (emerg_ok) begin
        phase <= PH_Y;
        count <= '0;
        next_dir <= bus.emerg_dir;
      end else if (bus.tick_en) begin
        if (count != G_END) count <= count + 1'b1;
        else if (found) begin
          phase <= PH_Y;
          count <= '0;
          next_dir <= sel;
        end
      end
    end else if (phase == PH_Y) begin
      if (emerg_ok) next_dir <= bus.emerg_dir;
      if (bus.tick_en) begin
        count <= count == Y_END ? '0 : count + 1'b1;
        if (count == Y_END) phase <= PH_AR;
      end
    end else begin
      if (emerg_ok) next_dir <= bus.emerg_dir;
      if (bus.tick_en) begin
        count <= count == AR_END ? '0 : count + 1'b1;
        if (count == AR_END) begin
          phase <= PH_G;
          active <= emerg_ok ? bus.emerg_dir : next_dir;
        end
      end
    end
  end
  always_comb begin
    bus.lights = '0;
    if (phase == PH_G || phase == PH_Y) bus.lights[2*int'(active) +: 2] = phase == PH_G ? 2'd2 : 2'd1;
  end
  assign bus.active_dir = active;
  assign bus.phase = phase;
  assign bus.emerg_ack = hold && phase == PH_G;
endmodule
